// File: rtl/gf2m_pkg.sv
// Shared definitions for the GF(2^M) multiplier slice.
//   M163 / POLY163 : default field, x^163 + x^7 + x^6 + x^3 + 1 (x^M implicit)
//   clmul_width()  : width of a W x W carry-less product
//   RED_RAW/RED_MOD: encoding of the per-transaction reduce flag
package gf2m_pkg;

    localparam int           M163    = 163;
    localparam logic [162:0] POLY163 = 163'hC9;

    localparam logic RED_RAW = 1'b0;
    localparam logic RED_MOD = 1'b1;

    function automatic int clmul_width(input int w);
        return 2 * w - 1;
    endfunction

endpackage

// File: rtl/gf2_clmul.sv
// Combinational schoolbook carry-less multiplier, W x W -> 2W-1 bits.
// Ports:
//   a, b : W-bit polynomials over GF(2), bit i = coefficient of x^i
//   p    : 2W-1-bit carry-less product
module gf2_clmul
    import gf2m_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]                a,
    input  logic [W-1:0]                b,
    output logic [clmul_width(W)-1:0]   p
);

    localparam int PW = clmul_width(W);

    logic [PW-1:0] a_ext;

    always_comb begin
        a_ext        = '0;
        a_ext[W-1:0] = a;
        p            = '0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) begin
                p = p ^ (a_ext << i);
            end
        end
    end

endmodule

// File: rtl/gf2m_karatsuba_mul_pipe.sv
// Three-stage pipelined GF(2^M) multiplier using one level of Karatsuba
// splitting (three half-size carry-less products) with optional reduction
// modulo the field polynomial, chosen per transaction.
// Ports:
//   clk, rst               : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready      : operand handshake; in_ready = global advance
//   in_a, in_b             : M-bit operands
//   in_reduce              : 1 = return A*B mod POLY, 0 = raw 2M-1-bit product
//   out_valid/out_ready    : result handshake
//   out_c                  : result (upper M-1 bits zero when reduced)
//   out_reduced            : reduce flag travelling with the result
// The pipeline is a rigid shift: every stage moves only when the output
// register is empty or being drained, so bubbles are never squeezed out.
module gf2m_karatsuba_mul_pipe
    import gf2m_pkg::*;
#(
    parameter int           M    = M163,
    parameter logic [M-1:0] POLY = POLY163
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [M-1:0]    in_a,
    input  logic [M-1:0]    in_b,
    input  logic            in_reduce,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*M-2:0]  out_c,
    output logic            out_reduced
);

    // Low half gets the floor, so for odd M the high half is one bit wider.
    localparam int P  = M / 2;
    localparam int H  = M - P;
    localparam int RW = 2 * M - 1;
    localparam int HW = clmul_width(H);
    localparam int LW = clmul_width(P);

    // Recombine the three half products. HH is placed at x^(2P), which
    // equals x^M only for even M.
    function automatic logic [RW-1:0] karatsuba_join(
        input logic [HW-1:0] hh,
        input logic [LW-1:0] ll,
        input logic [HW-1:0] mm
    );
        logic [RW-1:0] hh_x;
        logic [RW-1:0] ll_x;
        logic [RW-1:0] mid_x;
        hh_x            = '0;
        hh_x[HW-1:0]    = hh;
        ll_x            = '0;
        ll_x[LW-1:0]    = ll;
        mid_x           = '0;
        mid_x[HW-1:0]   = mm ^ hh;
        mid_x           = mid_x ^ ll_x;
        return (hh_x << (2 * P)) ^ (mid_x << P) ^ ll_x;
    endfunction

    // Fold bits 2M-2..M back down, highest first. XORing the full field
    // polynomial (x^M included) clears the bit being folded.
    function automatic logic [RW-1:0] reduce_mod(input logic [RW-1:0] r_in);
        logic [RW-1:0] r;
        logic [RW-1:0] f;
        r          = r_in;
        f          = '0;
        f[M-1:0]   = POLY;
        f[M]       = 1'b1;
        for (int i = RW - 1; i >= M; i--) begin
            if (r[i]) begin
                r = r ^ (f << (i - M));
            end
        end
        return r;
    endfunction

    logic adv;

    logic          vld_p1_q, vld_p1_d;
    logic          red_p1_q, red_p1_d;
    logic [H-1:0]  a_h_p1_q, a_h_p1_d;
    logic [P-1:0]  a_l_p1_q, a_l_p1_d;
    logic [H-1:0]  b_h_p1_q, b_h_p1_d;
    logic [P-1:0]  b_l_p1_q, b_l_p1_d;
    logic [H-1:0]  sa_p1_q,  sa_p1_d;
    logic [H-1:0]  sb_p1_q,  sb_p1_d;
    logic [H-1:0]  a_l_ext;
    logic [H-1:0]  b_l_ext;

    logic          vld_p2_q, vld_p2_d;
    logic          red_p2_q, red_p2_d;
    logic [HW-1:0] hh_p2_q,  hh_p2_d;
    logic [LW-1:0] ll_p2_q,  ll_p2_d;
    logic [HW-1:0] mm_p2_q,  mm_p2_d;
    logic [HW-1:0] hh_w;
    logic [LW-1:0] ll_w;
    logic [HW-1:0] mm_w;

    logic          vld_p3_q, vld_p3_d;
    logic          red_p3_q, red_p3_d;
    logic [RW-1:0] c_p3_q,   c_p3_d;
    logic [RW-1:0] raw_w;

    gf2_clmul #(.W(H)) u_mul_hh (.a(a_h_p1_q), .b(b_h_p1_q), .p(hh_w));
    gf2_clmul #(.W(P)) u_mul_ll (.a(a_l_p1_q), .b(b_l_p1_q), .p(ll_w));
    gf2_clmul #(.W(H)) u_mul_mm (.a(sa_p1_q),  .b(sb_p1_q),  .p(mm_w));

    always_comb begin
        adv = !vld_p3_q || out_ready;

        vld_p1_d = adv ? in_valid : vld_p1_q;
        vld_p2_d = adv ? vld_p1_q : vld_p2_q;
        vld_p3_d = adv ? vld_p2_q : vld_p3_q;

        // Stage 1: split operands and form the half sums
        a_l_ext          = '0;
        a_l_ext[P-1:0]   = in_a[P-1:0];
        b_l_ext          = '0;
        b_l_ext[P-1:0]   = in_b[P-1:0];
        a_h_p1_d = a_h_p1_q;
        a_l_p1_d = a_l_p1_q;
        b_h_p1_d = b_h_p1_q;
        b_l_p1_d = b_l_p1_q;
        sa_p1_d  = sa_p1_q;
        sb_p1_d  = sb_p1_q;
        red_p1_d = red_p1_q;
        if (adv && in_valid) begin
            a_h_p1_d = in_a[M-1:P];
            a_l_p1_d = in_a[P-1:0];
            b_h_p1_d = in_b[M-1:P];
            b_l_p1_d = in_b[P-1:0];
            sa_p1_d  = in_a[M-1:P] ^ a_l_ext;
            sb_p1_d  = in_b[M-1:P] ^ b_l_ext;
            red_p1_d = in_reduce;
        end

        // Stage 2: three half-size carry-less products
        hh_p2_d  = hh_p2_q;
        ll_p2_d  = ll_p2_q;
        mm_p2_d  = mm_p2_q;
        red_p2_d = red_p2_q;
        if (adv && vld_p1_q) begin
            hh_p2_d  = hh_w;
            ll_p2_d  = ll_w;
            mm_p2_d  = mm_w;
            red_p2_d = red_p1_q;
        end

        // Stage 3: recombine, optionally reduce, hold for the consumer
        raw_w    = karatsuba_join(hh_p2_q, ll_p2_q, mm_p2_q);
        c_p3_d   = c_p3_q;
        red_p3_d = red_p3_q;
        if (adv && vld_p2_q) begin
            c_p3_d   = (red_p2_q == RED_MOD) ? reduce_mod(raw_w) : raw_w;
            red_p3_d = red_p2_q;
        end
    end

    // Output register is cleared with the valids so a reset shows a zero result.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            c_p3_q   <= '0;
            red_p3_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            c_p3_q   <= c_p3_d;
            red_p3_q <= red_p3_d;
        end
    end

    always_ff @(posedge clk) begin
        a_h_p1_q <= a_h_p1_d;
        a_l_p1_q <= a_l_p1_d;
        b_h_p1_q <= b_h_p1_d;
        b_l_p1_q <= b_l_p1_d;
        sa_p1_q  <= sa_p1_d;
        sb_p1_q  <= sb_p1_d;
        red_p1_q <= red_p1_d;
        hh_p2_q  <= hh_p2_d;
        ll_p2_q  <= ll_p2_d;
        mm_p2_q  <= mm_p2_d;
        red_p2_q <= red_p2_d;
    end

    assign in_ready    = adv;
    assign out_valid   = vld_p3_q;
    assign out_c       = c_p3_q;
    assign out_reduced = red_p3_q;

endmodule

// File: tb/tb_gf2m_karatsuba_mul_pipe.sv
// Bench for gf2m_karatsuba_mul_pipe: an M=8 AES-field instance for the
// textbook vector and an M=163 instance driven from stimulus queues and
// checked by a scoreboard against a bit-level reference model.
module tb_gf2m_karatsuba_mul_pipe;

    localparam int           M    = 163;
    localparam int           RW   = 2 * M - 1;
    localparam logic [M-1:0] POLY = 163'hC9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          in_valid, in_ready, in_reduce;
    logic          out_valid, out_ready, out_reduced;
    logic [M-1:0]  in_a, in_b;
    logic [RW-1:0] out_c;

    logic          in_valid8, in_ready8, in_reduce8;
    logic          out_valid8, out_ready8, out_reduced8;
    logic [7:0]    in_a8, in_b8;
    logic [14:0]   out_c8;

    gf2m_karatsuba_mul_pipe #(.M(M), .POLY(POLY)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_reduce(in_reduce),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_reduced(out_reduced)
    );

    gf2m_karatsuba_mul_pipe #(.M(8), .POLY(8'h1B)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .in_reduce(in_reduce8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_c(out_c8), .out_reduced(out_reduced8)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_out   = 0;
    bit mon_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [RW-1:0] c;
        logic          red;
        int            acc;
    } exp_t;

    exp_t          exp_q[$];
    logic [M-1:0]  st_a[$];
    logic [M-1:0]  st_b[$];
    logic          st_r[$];
    logic [RW-1:0] st_e[$];

    task automatic check_val(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Plain bit-by-bit polynomial product.
    function automatic logic [RW-1:0] ref_clmul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                r[i+j] = r[i+j] ^ (a[i] & b[j]);
        return r;
    endfunction

    // Horner-style field multiply: acc = acc*x mod f, then add A if b_j set.
    function automatic logic [M-1:0] ref_modmul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic         top;
        acc = '0;
        for (int j = M - 1; j >= 0; j--) begin
            top = acc[M-1];
            acc = acc << 1;
            if (top) acc = acc ^ POLY;
            if (b[j]) acc = acc ^ a;
        end
        return acc;
    endfunction

    function automatic logic [RW-1:0] ref_mul(input logic [M-1:0] a, input logic [M-1:0] b, input logic red);
        logic [RW-1:0] r;
        r = '0;
        if (red) r[M-1:0] = ref_modmul(a, b);
        else     r = ref_clmul(a, b);
        return r;
    endfunction

    function automatic logic [M-1:0] rand_op();
        logic [191:0] t;
        for (int k = 0; k < 6; k++) t[k*32 +: 32] = $urandom;
        return t[M-1:0];
    endfunction

    task automatic add_op(input logic [M-1:0] a, input logic [M-1:0] b, input logic r, input logic [RW-1:0] e);
        st_a.push_back(a);
        st_b.push_back(b);
        st_r.push_back(r);
        st_e.push_back(e);
    endtask

    // Scoreboard: every output transfer is matched in order.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!rst && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check_val("spurious_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check_val("out_c", out_c, e.c);
                check_val("out_reduced", out_reduced, e.red);
                if (e.red) check_val("reduced_hi_zero", out_c >> M, 0);
                if (mon_lat) check_val("latency_edges", cyc - e.acc + 1, 3);
            end
        end
    end

    // Drive the stimulus queues at full rate; optionally hold out_ready low
    // for stall_len cycles starting at the first out_valid.
    task automatic run_stream(input int stall_len, input bit lat);
        int            idx;
        int            guard;
        int            n;
        int            out0;
        int            stall_left;
        bit            took;
        bit            held_ok;
        logic [RW-1:0] held;
        idx = 0; guard = 0; n = st_a.size(); out0 = n_out;
        stall_left = stall_len; held_ok = 0; held = '0;
        mon_lat = lat;
        @(negedge clk);
        while ((idx < n || exp_q.size() != 0) && guard < n + 100) begin
            if (stall_left > 0 && out_valid) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (idx < n) begin
                in_valid = 1'b1; in_a = st_a[idx]; in_b = st_b[idx]; in_reduce = st_r[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready) begin
                check_val("stall_in_ready", in_ready, 0);
                if (held_ok) check_val("stall_hold_c", out_c, held);
                held = out_c; held_ok = 1;
            end else begin
                held_ok = 0;
            end
            took = in_valid && in_ready;
            @(posedge clk);
            @(negedge clk);
            if (took) begin
                exp_q.push_back('{st_e[idx], st_r[idx], cyc});
                idx++;
            end
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_val("stream_all_sent", idx, n);
        check_val("stream_drained", exp_q.size(), 0);
        @(negedge clk);
        check_val("stream_delivered", n_out - out0, n);
        st_a.delete(); st_b.delete(); st_r.delete(); st_e.delete();
        mon_lat = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] e;
        logic [M-1:0]  a, b, xh;

        rst = 1'b1;
        in_valid = 0; in_a = '0; in_b = '0; in_reduce = 0; out_ready = 1;
        in_valid8 = 0; in_a8 = '0; in_b8 = '0; in_reduce8 = 0; out_ready8 = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_c", out_c, 0);
        check_val("rst_out_reduced", out_reduced, 0);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst8_out_valid", out_valid8, 0);

        // AES field textbook vector, raw then reduced, back to back.
        @(negedge clk);
        in_a8 = 8'h57; in_b8 = 8'h83; in_reduce8 = 0; in_valid8 = 1;
        #1 check_val("m8_in_ready", in_ready8, 1);
        @(negedge clk);
        in_reduce8 = 1;
        @(negedge clk);
        in_valid8 = 0;
        #1 check_val("m8_not_early", out_valid8, 0);
        @(negedge clk);
        #1;
        check_val("m8_raw_valid", out_valid8, 1);
        check_val("m8_raw_c", out_c8, 15'h2B79);
        check_val("m8_raw_flag", out_reduced8, 0);
        @(negedge clk);
        #1;
        check_val("m8_red_valid", out_valid8, 1);
        check_val("m8_red_c", out_c8, 15'h00C1);
        check_val("m8_red_flag", out_reduced8, 1);
        @(negedge clk);
        #1 check_val("m8_drained", out_valid8, 0);

        // Directed M=163 boundary vectors.
        xh = '0; xh[162] = 1'b1;
        e = '0; e[162] = 1'b1;
        add_op(163'h1, xh, 1'b1, e);
        e = '0; e[163] = 1'b1;
        add_op(163'h2, xh, 1'b0, e);
        e = '0; e[7:0] = 8'hC9;
        add_op(163'h2, xh, 1'b1, e);
        add_op('0, rand_op(), 1'b0, '0);
        add_op(rand_op(), '0, 1'b1, '0);
        run_stream(0, 1'b1);

        // Odd split, raw products, back to back.
        for (int i = 0; i < 1000; i++) begin
            a = rand_op(); b = rand_op();
            add_op(a, b, 1'b0, ref_mul(a, b, 1'b0));
        end
        run_stream(0, 1'b1);

        // Mode alternating every beat.
        for (int i = 0; i < 200; i++) begin
            a = rand_op(); b = rand_op();
            add_op(a, b, (i % 2) == 0, ref_mul(a, b, (i % 2) == 0));
        end
        run_stream(0, 1'b1);

        // Backpressure: 5 back-to-back ops, 4-cycle stall at first output.
        for (int i = 0; i < 5; i++) begin
            a = rand_op(); b = rand_op();
            add_op(a, b, i[0], ref_mul(a, b, i[0]));
        end
        run_stream(4, 1'b0);

        // Reset with two operations in flight.
        @(negedge clk);
        in_a = rand_op(); in_b = rand_op(); in_reduce = 0; in_valid = 1;
        @(negedge clk);
        in_a = rand_op(); in_reduce = 1;
        @(negedge clk);
        in_valid = 0; rst = 1;
        exp_q.delete();
        @(negedge clk);
        rst = 0;
        #1;
        check_val("midrst_out_valid", out_valid, 0);
        check_val("midrst_out_c", out_c, 0);
        check_val("midrst_in_ready", in_ready, 1);
        a = rand_op(); b = rand_op();
        add_op(a, b, 1'b1, ref_mul(a, b, 1'b1));
        run_stream(0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gf2m_karatsuba_mul_pipe.md
Name: gf2m_karatsuba_mul_pipe

Overview:
- Parametrised, pipelined binary-field (GF(2^M)) multiplier.
- Computes the carry-less product of two M-bit polynomials using one level of Karatsuba splitting, with three half-size products.
- Optionally reduces the product modulo an irreducible trinomial/pentanomial, selected per transaction.
- Sits between the ECC point-arithmetic sequencer and the field register file; valid/ready on both sides, full throughput of one operation per cycle.

Parameters:
- M, 163, field degree / operand width (M >= 4; odd M allowed).
- POLY, 163'hC9, low M bits of the field polynomial; x^M is implicit. Default is x^163+x^7+x^6+x^3+1.
- P, M/2 (floor), split point. Derived; not to be overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts the operand pair this cycle.
- in_a  input  M  operand A, bit i = coefficient of x^i.
- in_b  input  M  operand B.
- in_reduce  input  1  1: return A*B mod POLY; 0: return the raw 2M-1-bit product.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_c  output  2M-1  result. When reduced, bits [2M-2:M] are 0.
- out_reduced  output  1  in_reduce value carried with the result.

Behaviour:
- Reset: one cycle with rst=1 clears all stage valid bits. After reset: out_valid=0, out_c=0, out_reduced=0, in_ready=1. An in-flight operation is discarded, not completed.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. All stages load only when adv=1.
- Transfer rules:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Split widths: A_l = A[P-1:0]; A_h = A[M-1:P] (width H = M-P). Same split for B.
- S1 (register): A_h, A_l, B_h, B_l, SA = A_h ^ zext(A_l), SB = B_h ^ zext(B_l), reduce flag, valid.
- S2 (register): three products via sub-module instances:
  - HH = A_h*B_h, width 2H-1.
  - LL = A_l*B_l, width 2P-1.
  - MM = SA*SB, width 2H-1.
  - Carries reduce flag and valid.
- S3 (output register):
  - Raw result R = (HH << 2P) ^ ((MM ^ HH ^ LL) << P) ^ LL, all zero-extended to 2M-1 bits. Shift for HH is 2P, not M: this is required for odd M.
  - If reduce=1: for i = 2M-2 down to M, if R[i] set then R ^= (POLY << (i-M)) and clear bit i. out_c = zext(R[M-1:0]).
  - If reduce=0: out_c = R.
- Latency: exactly 3 clock edges from input transfer to out_valid, when out_ready stays high. Throughput: 1 per cycle.
- Backpressure:
  - out_valid=1 && out_ready=0 freezes all stages and drops in_ready.
  - out_c and out_reduced hold stable while stalled.
  - Bubbles are not compressed; the pipeline is a rigid shift.
- Simultaneous input and output transfer in one cycle is legal and required for full throughput.
- Ordering: results leave in acceptance order. No IDs.
- Zero operand gives zero result in both modes. in_reduce may change every transaction.
- All arithmetic is GF(2): XOR only, no carries.

Decomposition:
- Shared package gf2m_pkg:
  - Field constants: M163 = 163, POLY163 = 163'hC9.
  - Function clmul_width(w) = 2w-1.
  - Reduce-flag encoding constants.
- Sub-module gf2_clmul (parameter W): combinational schoolbook carry-less multiply, W x W -> 2W-1. Instantiated three times: twice with W=H, once with W=P.
- Reduction stays inline in S3 as a generate/for loop.

Test Plan:
- M=8, POLY=8'h1B:
  - A=57h, B=83h, reduce=0 -> out_c=15'h2B79, 3 cycles after accept.
  - Same with reduce=1 -> out_c=15'h00C1.
- M=163 default:
  - A=1, B=x^162, reduce=1 -> out_c bit 162 only.
  - A=x, B=x^162, reduce=0 -> bit 163 only.
  - A=x, B=x^162, reduce=1 -> out_c=163'hC9.
- Odd split check, M=163: random A,B, reduce=0 -> matches the bench schoolbook model (P=81, H=82); 1000 vectors, back-to-back.
- Backpressure: 5 back-to-back inputs, out_ready=0 for 4 cycles from the first out_valid.
  - in_ready=0 during the stall.
  - out_c stable during the stall.
  - All 5 results delivered in order, none lost or duplicated.
- Reset mid-operation: 2 ops in flight, rst=1 for one cycle.
  - Next cycle: out_valid=0, out_c=0, in_ready=1.
  - A new op afterwards completes in 3 cycles with the correct value.
- Mixed mode: alternate in_reduce 1/0 per beat at full throughput.
  - out_reduced tracks each beat.
  - Reduced results have bits [2M-2:M]=0.
